wb_queue_unit: RTL and testbench
================================

Name: wb_queue_unit

Overview:
- Parametrised write-back stage for the pipelined core.
- Takes retiring results from the MEM stage and selects among four write-back sources.
- Buffers accepted register writes in a DEPTH-entry FIFO, drained into the register file's single write port under a ready handshake.
- Optionally exposes a forwarding lookup so EX can read values still queued.

Parameters:
DATA_W, 16, data width of all sources and write-back data
REG_AW, 4, register address width (2**REG_AW registers, register 0 hardwired zero)
DEPTH, 4, write-queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  MEM stage presents a retiring instruction
in_ready  out  1  queue can accept this cycle
wb_sel  in  2  source: 0 alu_result, 1 mem_read_data, 2 pc_link, 3 imm_data
reg_write_in  in  1  instruction writes a register
reg_rd_in  in  REG_AW  destination register
alu_result  in  DATA_W  ALU result
mem_read_data  in  DATA_W  load data
pc_link  in  DATA_W  return address for call
imm_data  in  DATA_W  immediate (LHB/LLB style)
reg_wr_ready  in  1  register file accepts a write this cycle
RegWrite  out  1  head entry valid, write requested
reg_rd_out  out  REG_AW  head entry destination
write_back_data  out  DATA_W  head entry data
count  out  $clog2(DEPTH)+1  occupied entries
fwd_rd  in  REG_AW  EX-stage source register to look up
fwd_hit  out  1  fwd_rd matches a queued entry
fwd_data  out  DATA_W  data of youngest matching entry

Behaviour:
- Reset (async, rst=1): write/read pointers=0, count=0, RegWrite=0, reg_rd_out=0, write_back_data=0, fwd_hit=0, fwd_data=0. Queued entries are discarded, including on reset mid-drain.
- in_ready = (count < DEPTH). Combinational from registered count; no same-cycle pop bypass.
- Accept = in_valid && in_ready.
  - If reg_write_in=1 and reg_rd_in!=0: push {reg_rd_in, selected data}. The source mux is evaluated in the accept cycle.
  - Otherwise the instruction is accepted and dropped; count is unchanged.
- in_valid while in_ready=0: nothing is stored. Upstream must hold.
- Latency: a pushed entry becomes visible at the head one cycle after the accept edge, at the earliest.
- Output: RegWrite = (count!=0).
  - While RegWrite=1: reg_rd_out/write_back_data = head entry.
  - While RegWrite=0: both are forced to 0.
- Pop = RegWrite && reg_wr_ready. The head advances on that edge.
- Ordering: strict FIFO; writes reach the regfile in retirement order.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at count=DEPTH-1 and below; at count=DEPTH no push occurs.
- Pointers wrap modulo DEPTH. Count saturates logically at DEPTH and 0; pop on empty and push on full cannot occur.
- Forwarding (when compiled in):
  - Combinational compare of fwd_rd against all valid entries.
  - fwd_hit=1 if any entry matches; fwd_data = youngest match (closest to write pointer).
  - fwd_rd=0 always gives fwd_hit=0, fwd_data=0.
  - The entry being popped this cycle still counts as a hit.

Optional Feature:
- WB_FWD_EN defined: fwd_rd/fwd_hit/fwd_data are active as described, with a DEPTH-way compare plus youngest-priority select.
- Not defined: ports remain, fwd_hit and fwd_data are tied to 0, fwd_rd is ignored, and no compare logic is built. The hazard unit must then stall EX while count!=0.

Test Plan:
- Reset mid-operation: queue 3 entries with reg_wr_ready=0, assert rst -> same cycle count=0, RegWrite=0, reg_rd_out=0, write_back_data=0; after release in_ready=1.
- Source select: reg_write_in=1, rd=5, alu=0x1111, mem=0x2222, link=0x3333, imm=0x4444; wb_sel 0..3 in four accepts, reg_wr_ready=1 -> regfile writes r5 = 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, each one cycle after its accept.
- Full/backpressure: reg_wr_ready=0, push 4 entries (r1..r4) -> count=4, in_ready=0; a fifth in_valid is held and not stored. Raise reg_wr_ready -> writes r1, r2, r3, r4 in order, then the fifth.
- Drop rules: accepts with reg_write_in=0 (rd=7) and with rd=0, reg_write_in=1 -> in_ready stays 1, count stays 0, RegWrite never asserts.
- Wrap plus simultaneous push/pop: continuous in_valid with reg_wr_ready toggling every cycle for 20 accepts -> count never exceeds DEPTH, all 20 writes retire in order, no loss or duplication.
- Forwarding (WB_FWD_EN): queue r3=0x00AA then r3=0x00BB, reg_wr_ready=0, fwd_rd=3 -> fwd_hit=1, fwd_data=0x00BB; fwd_rd=4 -> fwd_hit=0. Without the macro -> fwd_hit=0 and fwd_data=0 throughout.

Source files
------------

// File: rtl/wb_queue_unit.sv
// Write-back stage: selects one of four result sources and queues register writes in a
// DEPTH-entry FIFO drained into the register file. Define WB_FWD_EN to build the forwarding lookup.
module wb_queue_unit #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 wb_sel,
    input  logic                       reg_write_in,
    input  logic [REG_AW-1:0]          reg_rd_in,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic [DATA_W-1:0]          mem_read_data,
    input  logic [DATA_W-1:0]          pc_link,
    input  logic [DATA_W-1:0]          imm_data,
    input  logic                       reg_wr_ready,
    output logic                       RegWrite,
    output logic [REG_AW-1:0]          reg_rd_out,
    output logic [DATA_W-1:0]          write_back_data,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [REG_AW-1:0]          fwd_rd,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [REG_AW-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [DATA_W-1:0] sel_data;
    logic              push;
    logic              pop;

    always_comb begin
        sel_data = alu_result;
        case (wb_sel)
            2'd0:    sel_data = alu_result;
            2'd1:    sel_data = mem_read_data;
            2'd2:    sel_data = pc_link;
            default: sel_data = imm_data;
        endcase
    end

    // Accepted instructions that do not write a real register are consumed without a slot.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && reg_write_in && (reg_rd_in != '0);
    assign RegWrite = (count_q != '0);
    assign pop      = RegWrite && reg_wr_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: nothing is visible unless count marks it valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= reg_rd_in;
            data_mem_q[wr_ptr_q] <= sel_data;
        end
    end

    assign count           = count_q;
    assign reg_rd_out      = RegWrite ? rd_mem_q[rd_ptr_q]   : '0;
    assign write_back_data = RegWrite ? data_mem_q[rd_ptr_q] : '0;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (fwd_rd != '0) && (rd_mem_q[fwd_idx] == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd_rd;

    assign unused_fwd_rd = ^fwd_rd;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_wb_queue_unit.sv
// Directed bench for wb_queue_unit: reset, source select, backpressure, drop rules,
// wrap with concurrent push/pop, and forwarding lookup.
module tb_wb_queue_unit;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        wb_sel;
    logic              reg_write_in;
    logic [REG_AW-1:0] reg_rd_in;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] pc_link;
    logic [DATA_W-1:0] imm_data;
    logic              reg_wr_ready;
    logic              RegWrite;
    logic [REG_AW-1:0] reg_rd_out;
    logic [DATA_W-1:0] write_back_data;
    logic [2:0]        count;
    logic [REG_AW-1:0] fwd_rd;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_queue_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .wb_sel(wb_sel),
        .reg_write_in(reg_write_in), .reg_rd_in(reg_rd_in), .alu_result(alu_result),
        .mem_read_data(mem_read_data), .pc_link(pc_link), .imm_data(imm_data),
        .reg_wr_ready(reg_wr_ready), .RegWrite(RegWrite), .reg_rd_out(reg_rd_out),
        .write_back_data(write_back_data), .count(count), .fwd_rd(fwd_rd),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        wb_sel        = 2'd0;
        reg_write_in  = 1'b0;
        reg_rd_in     = '0;
        alu_result    = '0;
        mem_read_data = '0;
        pc_link       = '0;
        imm_data      = '0;
        reg_wr_ready  = 1'b0;
        fwd_rd        = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 3'd0 || RegWrite !== 1'b0 || in_ready !== 1'b1 ||
            reg_rd_out !== 4'd0 || write_back_data !== 16'h0 || fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: count=%0d RegWrite=%b in_ready=%b rd=%0d data=%h hit=%b fdata=%h, expected 0 0 1 0 0 0 0",
                     count, RegWrite, in_ready, reg_rd_out, write_back_data, fwd_hit, fwd_data);
        end
        reg_wr_ready = 1'b0;
        in_valid     = 1'b1;
        reg_write_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reg_rd_in  = REG_AW'(i + 1);
            alu_result = 16'hA000 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill: count=%0d RegWrite=%b, expected 3 1", count, RegWrite);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || RegWrite !== 1'b0 || reg_rd_out !== 4'd0 || write_back_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: count=%0d RegWrite=%b rd=%0d data=%h, expected 0 0 0 0",
                     count, RegWrite, reg_rd_out, write_back_data);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b count=%0d, expected 1 0", in_ready, count);
        end
    endtask

    task automatic test_source_select();
        logic [DATA_W-1:0] exp_data [4];
        exp_data[0] = 16'h1111;
        exp_data[1] = 16'h2222;
        exp_data[2] = 16'h3333;
        exp_data[3] = 16'h4444;
        do_reset();
        reg_write_in  = 1'b1;
        reg_rd_in     = 4'd5;
        alu_result    = 16'h1111;
        mem_read_data = 16'h2222;
        pc_link       = 16'h3333;
        imm_data      = 16'h4444;
        reg_wr_ready  = 1'b1;
        in_valid      = 1'b1;
        for (int s = 0; s < 4; s++) begin
            wb_sel = 2'(s);
            step();
            if (s == 3) in_valid = 1'b0;
            checks++;
            if (RegWrite !== 1'b1 || reg_rd_out !== 4'd5 || write_back_data !== exp_data[s]) begin
                errors++;
                $display("FAIL src_sel%0d: RegWrite=%b rd=%0d data=%h, expected 1 5 %h",
                         s, RegWrite, reg_rd_out, write_back_data, exp_data[s]);
            end
        end
        step();
        checks++;
        if (RegWrite !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL src_drain: RegWrite=%b count=%0d, expected 0 0", RegWrite, count);
        end
    endtask

    task automatic test_full_backpressure();
        logic [REG_AW-1:0] exp_rd [5];
        bit accepted5;
        exp_rd[0] = 4'd1; exp_rd[1] = 4'd2; exp_rd[2] = 4'd3; exp_rd[3] = 4'd4; exp_rd[4] = 4'd6;
        do_reset();
        reg_wr_ready = 1'b0;
        reg_write_in = 1'b1;
        in_valid     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reg_rd_in  = REG_AW'(i + 1);
            alu_result = 16'h0100 + 16'(i + 1);
            step();
        end
        reg_rd_in  = 4'd6;
        alu_result = 16'h0106;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: count=%0d in_ready=%b, expected 4 0", count, in_ready);
        end
        step();
        step();
        checks++;
        if (count !== 3'd4 || reg_rd_out !== 4'd1) begin
            errors++;
            $display("FAIL full_hold: count=%0d head=%0d, expected 4 1", count, reg_rd_out);
        end
        reg_wr_ready = 1'b1;
        accepted5    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (RegWrite !== 1'b1 || reg_rd_out !== exp_rd[i] ||
                write_back_data !== (16'h0100 + 16'(exp_rd[i]))) begin
                errors++;
                $display("FAIL drain_order%0d: RegWrite=%b rd=%0d data=%h, expected 1 %0d %h",
                         i, RegWrite, reg_rd_out, write_back_data, exp_rd[i], 16'h0100 + 16'(exp_rd[i]));
            end
            if (in_valid && in_ready) accepted5 = 1'b1;
            step();
            if (accepted5) in_valid = 1'b0;
        end
        checks++;
        if (RegWrite !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL full_empty: RegWrite=%b count=%0d, expected 0 0", RegWrite, count);
        end
    endtask

    task automatic test_drop();
        do_reset();
        reg_wr_ready = 1'b1;
        in_valid     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            reg_write_in = (i == 1);
            reg_rd_in    = (i == 0) ? 4'd7 : 4'd0;
            alu_result   = 16'hDEAD;
            step();
            checks++;
            if (RegWrite !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL drop%0d: RegWrite=%b count=%0d in_ready=%b, expected 0 0 1",
                         i, RegWrite, count, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [REG_AW-1:0] q_rd [$];
        logic [DATA_W-1:0] q_data [$];
        int accepts = 0;
        int retired = 0;
        int cyc = 0;
        bit over = 1'b0;
        do_reset();
        reg_write_in = 1'b1;
        in_valid     = 1'b1;
        while ((accepts < 20 || q_rd.size() != 0) && cyc < 200) begin
            reg_wr_ready = cyc[0];
            in_valid     = (accepts < 20);
            reg_rd_in    = REG_AW'(1 + (accepts % 15));
            alu_result   = 16'hC000 + 16'(accepts);
            if (count > 3'd4) over = 1'b1;
            if (RegWrite && reg_wr_ready) begin
                checks++;
                if (q_rd.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_extra: unexpected write rd=%0d data=%h, expected none",
                             reg_rd_out, write_back_data);
                end else begin
                    if (reg_rd_out !== q_rd[0] || write_back_data !== q_data[0]) begin
                        errors++;
                        $display("FAIL wrap_order%0d: rd=%0d data=%h, expected %0d %h",
                                 retired, reg_rd_out, write_back_data, q_rd[0], q_data[0]);
                    end
                    void'(q_rd.pop_front());
                    void'(q_data.pop_front());
                end
                retired++;
            end
            if (in_valid && in_ready) begin
                q_rd.push_back(reg_rd_in);
                q_data.push_back(alu_result);
                accepts++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (retired !== 20 || over || cyc >= 200) begin
            errors++;
            $display("FAIL wrap_summary: retired=%0d overflow=%b cycles=%0d, expected 20 0 <200",
                     retired, over, cyc);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        reg_wr_ready = 1'b0;
        reg_write_in = 1'b1;
        in_valid     = 1'b1;
        reg_rd_in    = 4'd3;
        alu_result   = 16'h00AA;
        step();
        alu_result   = 16'h00BB;
        step();
        in_valid = 1'b0;
        fwd_rd   = 4'd3;
        #1;
`ifdef WB_FWD_EN
        checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 16'h00BB) begin
            errors++;
            $display("FAIL fwd_youngest: hit=%b data=%h, expected 1 00bb", fwd_hit, fwd_data);
        end
        fwd_rd = 4'd4;
        #1;
        checks++;
        if (fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL fwd_miss: hit=%b, expected 0", fwd_hit);
        end
        fwd_rd = 4'd0;
        #1;
        checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin
            errors++;
            $display("FAIL fwd_r0: hit=%b data=%h, expected 0 0000", fwd_hit, fwd_data);
        end
        step();
        fwd_rd       = 4'd3;
        reg_wr_ready = 1'b1;
        step();
        checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 16'h00BB || count !== 3'd1) begin
            errors++;
            $display("FAIL fwd_popping: hit=%b data=%h count=%0d, expected 1 00bb 1", fwd_hit, fwd_data, count);
        end
`else
        checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin
            errors++;
            $display("FAIL fwd_disabled: hit=%b data=%h, expected 0 0000", fwd_hit, fwd_data);
        end
        fwd_rd = 4'd4;
        step();
        checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 16'h0 || count !== 3'd2) begin
            errors++;
            $display("FAIL fwd_disabled2: hit=%b data=%h count=%0d, expected 0 0000 2", fwd_hit, fwd_data, count);
        end
`endif
        reg_wr_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_source_select();
        test_full_backpressure();
        test_drop();
        test_back_to_back();
        test_forwarding();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
